// File: rtl/uart_cfg_sequencer_if.sv
// rtl/uart_cfg_sequencer_if.sv - request/config/ack bundle between requesters and the UART config sequencer
interface uart_cfg_sequencer_if #(
  parameter int CFG_W = 9
);
  logic [1:0]       req;
  logic [CFG_W-1:0] cfg0;
  logic [CFG_W-1:0] cfg1;
  logic             uart_ready;
  logic [1:0]       ack;
  logic             err;
  logic             busy;
  logic             hold;
  logic             set_l;
  logic [CFG_W-1:0] cfg_out;

  modport master (
    output req, cfg0, cfg1, uart_ready,
    input  ack, err, busy, hold, set_l, cfg_out
  );

  modport slave (
    input  req, cfg0, cfg1, uart_ready,
    output ack, err, busy, hold, set_l, cfg_out
  );
endinterface

// File: rtl/uart_cfg_sequencer.sv
// rtl/uart_cfg_sequencer.sv - arbitrates UART reconfiguration requests and strobes uart_tuner once the datapath is idle
module uart_cfg_sequencer #(
  parameter int CFG_W         = 9,
  parameter int IDLE_TIMEOUT  = 1_000_000,
  parameter int SETTLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  uart_cfg_sequencer_if.slave bus
);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CFG_W-1:0] TUNER_RESET = CFG_W'(9'h1D5);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    APPLY,
    SETTLE,
    DONE
  } state_t;

  state_t           state;
  logic             grant;
  logic             last;
  logic [TW-1:0]    timer;
  logic [SW-1:0]    scnt;
  logic [CFG_W-1:0] applied;

  logic             gsel;
  logic [CFG_W-1:0] gcfg;
  logic             gvalid;

  // On contention the requester not served last wins; a lone request is granted directly.
  always_comb begin
    gsel   = (bus.req == 2'b11) ? ~last : bus.req[1];
    gcfg   = gsel ? bus.cfg1 : bus.cfg0;
    gvalid = (gcfg[3:0] <= 4'd12) && (gcfg[5:4] != 2'b11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last        <= 1'b1;
      timer       <= '0;
      scnt        <= '0;
      applied     <= TUNER_RESET;
      bus.ack     <= 2'b00;
      bus.err     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.hold    <= 1'b0;
      bus.set_l   <= 1'b1;
      bus.cfg_out <= TUNER_RESET;
    end else begin
      case (state)
        IDLE: begin
          bus.ack <= 2'b00;
          bus.err <= 1'b0;
          if (bus.req != 2'b00) begin
            grant    <= gsel;
            bus.busy <= 1'b1;
            if (gvalid) begin
              bus.cfg_out <= gcfg;
              bus.hold    <= 1'b1;
              timer       <= '0;
              state       <= WAIT_IDLE;
            end else begin
              // Rejected words never reach cfg_out, so the tuner keeps the applied setting.
              bus.ack <= gsel ? 2'b10 : 2'b01;
              bus.err <= 1'b1;
              state   <= DONE;
            end
          end
        end
        WAIT_IDLE: begin
          if (bus.uart_ready) begin
            bus.set_l <= 1'b0;
            applied   <= bus.cfg_out;
            state     <= APPLY;
          end else if (timer == TW'(IDLE_TIMEOUT - 1)) begin
            bus.hold    <= 1'b0;
            bus.cfg_out <= applied;
            bus.ack     <= grant ? 2'b10 : 2'b01;
            bus.err     <= 1'b1;
            state       <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        APPLY: begin
          bus.set_l <= 1'b1;
          scnt      <= '0;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (scnt == SW'(SETTLE_CYCLES - 1)) begin
            bus.hold <= 1'b0;
            bus.ack  <= grant ? 2'b10 : 2'b01;
            bus.err  <= 1'b0;
            state    <= DONE;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        DONE: begin
          bus.ack  <= 2'b00;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          last     <= grant;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
